serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, captured on an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, captured on an accepted start.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, captured on an accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse, high while in DONE.
REQ-010 The block SHALL have port sum, output, WIDTH bits: result A+B+cin modulo 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1 at an edge, the FSM SHALL capture a, b and cin into shift registers and the carry flop, clear the bit counter and enter SHIFT.
REQ-014 In IDLE with start=0, the FSM SHALL remain in IDLE.
REQ-015 Each SHIFT cycle SHALL add one bit pair: LSB of A register, LSB of B register, carry flop.
REQ-016 The per-bit add SHALL be an 8-entry lookup indexed by {a_bit,b_bit,carry}, a_bit the MSB of the index.
REQ-017 The sum lookup SHALL be 0,1,1,0,1,0,0,1 for index 0..7; the carry lookup SHALL be 0,0,0,1,0,1,1,1.
REQ-018 Each SHIFT edge SHALL shift the A and B registers right by one and load the new carry into the carry flop.
REQ-019 Each SHIFT edge SHALL shift the sum bit into the MSB of the result register, so after WIDTH shifts bit 0 of the result sits in sum[0].
REQ-020 The counter SHALL be ceil(log2(WIDTH+1)) bits wide, count SHIFT cycles, and leave SHIFT after exactly WIDTH cycles.
REQ-021 On the last SHIFT edge, the FSM SHALL enter DONE with sum and cout (the final carry flop) valid.
REQ-022 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-023 Latency: if start is accepted at edge T, done SHALL be high during the cycle following edge T+WIDTH.
REQ-024 sum and cout SHALL hold their last result through IDLE until the next accepted start.
REQ-025 sum and cout MAY change during SHIFT; they are defined only when done=1 or in IDLE afterwards.
REQ-026 start in SHIFT or DONE SHALL be ignored and not queued, and operand inputs SHALL not be sampled then.
REQ-027 A start held high continuously SHALL be accepted once per IDLE visit, giving one addition per WIDTH+2 cycles.
REQ-028 Overflow SHALL wrap: sum is the low WIDTH bits and cout the carry; no other status is produced.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE and clear the counter, the carry flop, the A/B shift registers, sum (0) and cout (0).
REQ-030 rst=1 at an edge SHALL drive busy=0 and done=0 at the next edge.
REQ-031 rst SHALL take priority over start, and the same edge SHALL not accept an operation.
REQ-032 rst asserted during SHIFT or DONE SHALL abort the operation with no done pulse.

Verification
REQ-033 Scenario (WIDTH=8): a=0x0F, b=0x01, cin=0, start at edge T -> done high after edge T+8, sum=0x10, cout=0, busy high for exactly 8 cycles.
REQ-034 Scenario: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
REQ-035 Scenario: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; then a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0.
REQ-036 Scenario: second start with a=0x55 pulsed mid-SHIFT of 0x12+0x34 -> result 0x46, cout=0, no extra done pulse.
REQ-037 Scenario: rst asserted at the 4th SHIFT cycle -> next edge busy=0, done=0, sum=0x00, cout=0; a subsequent 0x80+0x80 gives sum=0x00, cout=1.
REQ-038 Scenario: start held high with constant operands -> done pulses every 10 cycles, identical results each time.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus a carry-in one bit per
// clock, LSB first, using a small lookup table as the full adder.
// One addition takes WIDTH SHIFT cycles followed by a single DONE cycle.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter just wide enough to hold the value WIDTH.
  localparam int CW = $clog2(WIDTH + 1);

  // Full-adder truth tables, indexed by {a_bit, b_bit, carry}.
  // Entry i sits in bit i of each constant.
  localparam logic [7:0] SUM_LUT   = 8'b1001_0110;
  localparam logic [7:0] CARRY_LUT = 8'b1110_1000;

  // Count value seen on the final SHIFT edge.
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;

  logic [2:0]       lut_idx;
  logic             sum_bit;
  logic             carry_bit;

  // Per-bit add: look up the sum and carry for the current bit pair.
  always_comb begin
    lut_idx   = {areg[0], breg[0], carry};
    sum_bit   = SUM_LUT[lut_idx];
    carry_bit = CARRY_LUT[lut_idx];
  end

  // Control FSM and datapath registers; status outputs are registered so
  // they track the state entered on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      areg   <= '0;
      breg   <= '0;
      result <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            areg   <= a;
            breg   <= b;
            carry  <= cin;
            cnt    <= '0;
            state  <= SHIFT;
            busy_q <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        SHIFT: begin
          areg   <= {1'b0, areg[WIDTH-1:1]};
          breg   <= {1'b0, breg[WIDTH-1:1]};
          result <= {sum_bit, result[WIDTH-1:1]};
          carry  <= carry_bit;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // The result register and the carry flop double as the visible outputs;
  // both hold still in IDLE until the next start is accepted.
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = result;
  assign cout = carry;

endmodule
